loss_accumulator: RTL
=====================

// Module: loss_accumulator
// PURPOSE
// - Downstream of the forward-propagation stage: consumes per-sample output error dAL (a4 - y), squares it,
//   and accumulates it per output neuron over a mini-batch of BATCH samples.
// - Publishes a per-neuron cost vector with a one-cycle valid strobe; feeds the training-control/readback path.
// PARAMETERS
// - L4      2   number of output neurons (width of dAL/cost vectors)
// - BATCH   4   samples per batch (>=1; power of two when LOSS_MEAN_EN defined)
// - DATA_W  16  dAL word width, signed fixed point (data_type)
// - FRAC_W  8   fractional bits of dAL
// - ACC_W   32  accumulator/cost width, unsigned (double_data_type)
// PORTS
// - clk           in   1            rising-edge clock
// - reset         in   1            asynchronous, active-high reset
// - enable        in   1            stage enable; low = pause (hold all state)
// - clear         in   1            sync abort: discard partial batch, counter to 0
// - sample_valid  in   1            dAL holds a new forward result this cycle
// - dAL           in   [0:L4-1] x DATA_W signed   per-neuron error
// - cost          out  [0:L4-1] x ACC_W  unsigned  last completed batch cost
// - cost_valid    out  1            1-cycle pulse: cost just updated
// - busy          out  1            batch in progress (ACCUM state)
// - sample_count  out  $clog2(BATCH+1)  samples accepted in current batch
// - overflow      out  1            sticky: some neuron saturated in current/last batch
// BEHAVIOUR
// - Reset (async): state IDLE; acc[*], cost[*], sample_count = 0; cost_valid, busy, overflow = 0.
// - Accept = enable & sample_valid & ~clear. Sample ignored when enable=0.
// - Term per neuron: sq = dAL*dAL (2*DATA_W unsigned); term = sq >> FRAC_W, zero-extended to ACC_W.
// - acc_next = acc + term; if carry out / exceeds 2^ACC_W-1 -> saturate to all-ones, set overflow.
// - FSM:
//   IDLE : busy=0. Accept -> acc=term, count=1, go ACCUM (or complete immediately if BATCH==1).
//   ACCUM: busy=1. Accept with count<BATCH-1 -> acc+=term, count++.
//          Accept with count==BATCH-1 -> cost<=final sum (incl. this term), acc<=0, count<=0,
//          cost_valid=1 next cycle, go IDLE. No bubble: a sample next cycle starts the new batch.
//   enable=0 in any state: hold acc, count, state; cost_valid still deasserts after its one cycle.
// - clear (sync, priority over accept): acc<=0, count<=0, overflow<=0, state IDLE; cost kept.
// - overflow clears when a new batch begins (first accept from IDLE) or on clear; otherwise sticky
//   through the completing batch so software can read it alongside cost.
// - Latency: cost/cost_valid register 1 cycle after the BATCH-th accepted sample.
// - cost holds stable between pulses; never partial values.
// - Reset mid-batch: all partial state lost, cost returns to 0.
// CONFIGURATION
// - LOSS_MEAN_EN defined: cost = final sum >> $clog2(BATCH) (mean squared error); saturation applied
//   before shift; BATCH must be power of two (elaboration-time $error otherwise).
// - LOSS_MEAN_EN undefined: cost = raw sum of squared errors; no BATCH restriction.
// TESTING (L4=2, BATCH=4, FRAC_W=8, ACC_W=32)
// - dAL={0x0100,0x0100} x4 accepts -> cost={0x400,0x400}, cost_valid 1 cycle after 4th; MEAN_EN: {0x100,0x100}.
// - dAL={-0x0200,0x0080} x4 -> cost={0x1000,0x100} (sign ignored; 0.5^2=0x40 per sample).
// - 2 accepts, enable=0 for 5 cycles with sample_valid=1, 2 more accepts -> exactly one pulse, count never >4.
// - 3 accepts then clear -> count=0, busy=0, no pulse, cost unchanged from prior batch.
// - ACC_W=16, dAL=0x7FFF x4 -> cost=0xFFFF, overflow=1; next batch first accept clears overflow.
// - Back-to-back 8 accepts -> two pulses, 4 cycles apart; assert reset during 2nd batch -> all outputs 0.

Source files
------------

// File: rtl/loss_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : loss_accumulator_if
//  Description : Control, sample and result signals between the loss
//                accumulator and its producer / training-control consumer.
//                The accumulator connects through the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface loss_accumulator_if #(
    parameter int L4     = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int BATCH  = 4
);
    localparam int c_CNT_W = $clog2(BATCH + 1);

    logic                      enable;
    logic                      clear;
    logic                      sample_valid;
    logic signed [DATA_W-1:0]  dAL [L4];
    logic        [ACC_W-1:0]   cost [L4];
    logic                      cost_valid;
    logic                      busy;
    logic        [c_CNT_W-1:0] sample_count;
    logic                      overflow;

    // Producer / controller side
    modport master (
        output enable, clear, sample_valid, dAL,
        input  cost, cost_valid, busy, sample_count, overflow
    );

    // Accumulator side
    modport slave (
        input  enable, clear, sample_valid, dAL,
        output cost, cost_valid, busy, sample_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/loss_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : loss_accumulator
//  Description : Squares the per-neuron output error dAL, accumulates it over
//                a mini-batch of BATCH samples with saturation, and publishes
//                the per-neuron cost with a one-cycle valid pulse.
//                Optional macro LOSS_MEAN_EN: cost is the saturated sum
//                divided by BATCH (BATCH must then be a power of two).
//  Revision    : 1.0 - initial release
// ============================================================================
module loss_accumulator #(
    parameter int L4     = 2,
    parameter int BATCH  = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    loss_accumulator_if.slave bus
);
    localparam int c_CNT_W  = $clog2(BATCH + 1);
    localparam int c_PROD_W = 2 * DATA_W;
    // One spare bit above the wider of accumulator and term catches carry-out
    localparam int c_SUM_W  = ((ACC_W > c_PROD_W) ? ACC_W : c_PROD_W) + 1;
`ifdef LOSS_MEAN_EN
    localparam int c_MEAN_SH = $clog2(BATCH);
`endif

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    // Elaboration-time parameter sanity
    if (BATCH < 1) begin : g_batch_check
        $error("loss_accumulator: BATCH must be at least 1");
    end
`ifdef LOSS_MEAN_EN
    if ((BATCH & (BATCH - 1)) != 0) begin : g_pow2_check
        $error("loss_accumulator: BATCH must be a power of two for mean mode");
    end
`endif

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc [L4];
    logic [ACC_W-1:0]   r_cost [L4];
    logic               r_cost_valid;
    logic               r_busy;
    logic               r_overflow;
    logic [c_CNT_W-1:0] r_count;

    logic               w_accept;
    logic               w_last;
    logic [L4-1:0]      w_sat;
    logic [ACC_W-1:0]   w_sum_sat [L4];

    // Clear takes priority, so a cleared cycle never counts as a sample
    assign w_accept = bus.enable & bus.sample_valid & ~bus.clear;
    // Counter is zero in IDLE, so BATCH==1 completes on the very first accept
    assign w_last   = (r_count == c_CNT_W'(BATCH - 1));

    // Per-neuron square, scale and saturating add
    for (genvar g = 0; g < L4; g++) begin : g_neuron
        logic signed [c_PROD_W-1:0] w_sq;
        logic        [c_PROD_W-1:0] w_term;
        logic        [c_SUM_W-1:0]  w_sum;

        assign w_sq   = bus.dAL[g] * bus.dAL[g];
        // Square is never negative, so it is reinterpreted as unsigned
        assign w_term = $unsigned(w_sq) >> FRAC_W;
        // A new batch starts from zero rather than from whatever acc holds
        assign w_sum  = ((r_state == S_ACCUM) ? c_SUM_W'(r_acc[g]) : '0)
                        + c_SUM_W'(w_term);
        assign w_sat[g]     = |w_sum[c_SUM_W-1:ACC_W];
        assign w_sum_sat[g] = w_sat[g] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

        assign bus.cost[g] = r_cost[g];
    end

    assign bus.cost_valid   = r_cost_valid;
    assign bus.busy         = r_busy;
    assign bus.sample_count = r_count;
    assign bus.overflow     = r_overflow;

    // Batch FSM: accumulate accepted samples, publish cost on the last one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_cost_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            for (int k = 0; k < L4; k++) begin
                r_acc[k]  <= '0;
                r_cost[k] <= '0;
            end
        end else begin
            // Pulse lasts exactly one cycle, even while paused
            r_cost_valid <= 1'b0;
            if (bus.clear) begin
                r_state    <= S_IDLE;
                r_count    <= '0;
                r_busy     <= 1'b0;
                r_overflow <= 1'b0;
                for (int k = 0; k < L4; k++) begin
                    r_acc[k] <= '0;
                end
            end else if (w_accept) begin
                // Sticky within a batch; a first accept from IDLE starts fresh
                r_overflow <= ((r_state == S_IDLE) ? 1'b0 : r_overflow) | (|w_sat);
                if (w_last) begin
                    r_state      <= S_IDLE;
                    r_count      <= '0;
                    r_busy       <= 1'b0;
                    r_cost_valid <= 1'b1;
                    for (int k = 0; k < L4; k++) begin
`ifdef LOSS_MEAN_EN
                        r_cost[k] <= w_sum_sat[k] >> c_MEAN_SH;
`else
                        r_cost[k] <= w_sum_sat[k];
`endif
                        r_acc[k]  <= '0;
                    end
                end else begin
                    r_state <= S_ACCUM;
                    r_count <= r_count + c_CNT_W'(1);
                    r_busy  <= 1'b1;
                    for (int k = 0; k < L4; k++) begin
                        r_acc[k] <= w_sum_sat[k];
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire
